pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- N-channel PWM generator; successor to the single-channel PWM.
- One shared prescaler sets the tick rate. One shared period counter runs in edge-aligned or center-aligned mode.
- Each channel has a double-buffered duty register with glitch-free updates at period boundaries, plus per-channel output polarity.
- Sits between the control/register logic and the gate-drive or LED outputs.

Parameters:
- CH, 4, number of channels (>=1).
- R, 8, counter resolution; edge period = 2^R ticks.
- TIMER_BITS, 10, prescaler width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global enable.
- final_value  in  TIMER_BITS  prescaler terminal count; tick every final_value+1 cycles.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary.
- duty_wr  in  1  one-cycle write strobe.
- duty_ch  in  max(1,clog2(CH))  channel index for the write.
- duty_in  in  R+1  duty value; 0 .. 2^R.
- polarity  in  CH  per channel; 1 = active-low output.
- pwm_out  out  CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse at each period boundary.
- duty_pending  out  CH  shadow value written but not yet applied.

Behaviour:
- Reset (async): tmr=0, cnt=0, dir=up, mode_act=0, shadow=0, duty_act=0, duty_pending=0, pwm_out=0, period_start=0.
- Prescaler: tmr counts 0..final_value. tick=1 when tmr==final_value, then tmr returns to 0. final_value=0 gives a tick every cycle. A final_value change takes effect at once; if tmr>final_value, tmr wraps through all-ones to 0.
- Edge mode: on tick, cnt increments 0..2^R-1 and wraps to 0.
- Center mode: on tick, cnt runs 0,1..2^R-1,2^R-2..1,0,1...
  - dir flips at 2^R-1 and at 0; each endpoint is visited once.
  - Period = 2*(2^R-1) ticks.
- Boundary: the tick on which cnt becomes 0. Also the first cycle after en rises.
- At boundary:
  - duty_act[i] <= shadow[i] for every i with duty_pending[i]=1; those pending bits clear.
  - mode_act <= center_mode.
  - period_start=1 for exactly one cycle, registered and aligned with cnt==0.
- Compare: active[i] = (cnt < duty_act[i]).
  - duty 0: always inactive.
  - duty >= 2^R: always active, with no one-tick gap at wrap.
  - Values above 2^R saturate as 2^R.
- Output: pwm_out[i] <= active[i] XOR polarity[i], registered. Output lags the cnt value by 1 cycle. Polarity changes apply on the next cycle.
- Writes:
  - duty_wr with duty_ch<CH: shadow[duty_ch] <= duty_in; duty_pending[duty_ch] <= 1.
  - duty_ch>=CH: write ignored, no state change.
  - Write and boundary in the same cycle on the same channel: boundary applies the old shadow; the new value lands in shadow and pending stays 1 for the next boundary.
  - A second write before a boundary overwrites shadow (last write wins).
- en=0:
  - tmr, cnt and dir are held at 0/up; period_start=0; pwm_out[i]=polarity[i] (inactive).
  - shadow, duty_act and pending are retained; writes are still accepted.
- en 0->1: the next cycle is a boundary (pending loaded, mode sampled, period_start pulse), then counting resumes from 0.
- Reset mid-period: all state returns to reset values immediately. The first cycle after release with en=1 is a boundary.

Decomposition:
- pwm_pkg holds:
  - mode encoding constants MODE_EDGE=0, MODE_CENTER=1;
  - localparams for CNT_MAX=2^R-1 and DUTY_FULL=2^R;
  - a helper function for the channel-index width.
- One sub-module, pwm_prescaler: tmr register and tick output, with inputs en, final_value and reset.
- Counter, shadow bank and compare/output stages stay in pwm_multi.

Test Plan:
- Baseline edge mode: CH=4, R=8, final_value=0, en=1, ch0 duty 128 -> pwm_out[0] high 128 cycles, low 128 cycles; period_start every 256 cycles.
- Duty extremes and polarity: ch1 duty 0 -> constant 0; ch2 duty 256 -> constant 1 across wrap; ch3 duty 300 -> constant 1; polarity[1]=1 -> constant 1.
- Shadow update: write ch1=64 at cnt=100 -> duty_pending[1]=1 and output unchanged until period_start; then a 64-cycle pulse and pending cleared. Write coinciding with the boundary defers to the following period.
- Center mode: center_mode=1, final_value=0, ch0 duty 128 -> period 510 cycles; ch0 high 255 contiguous cycles centered on cnt=0; mode switch applied only at a boundary.
- Prescaler: final_value=195 -> tick every 196 cycles; edge period 50176 cycles (≈1.99 kHz at 100 MHz).
- en/reset mid-period: en=0 at cnt=50 -> pwm_out=polarity next cycle and duty_pending kept; en=1 -> period_start next cycle with pending applied. Assert reset at cnt=77 -> all outputs 0 immediately, counters restart from 0 after release.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_pkg : shared encodings and sizing helpers for pwm_multi          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_max(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int duty_full(input int r);
    return 1 << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_prescaler : free-running tick divider, tick every final_value+1  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pwm_prescaler #(
  parameter int TIMER_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [TIMER_BITS-1:0] final_value,
  output logic                  tick
);

  logic [TIMER_BITS-1:0] r_tmr;
  logic                  w_hit;

  assign w_hit = (r_tmr == final_value);
  assign tick  = en & w_hit;

  // A lowered final_value below r_tmr lets the count run through all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr <= '0;
    end else if (!en || w_hit) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_multi : N-channel edge/center-aligned PWM with buffered duty     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int CH         = 4,
  parameter  int R          = 8,
  parameter  int TIMER_BITS = 10,
  localparam int CHW        = ch_idx_w(CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [TIMER_BITS-1:0] final_value,
  input  logic                  center_mode,
  input  logic                  duty_wr,
  input  logic [CHW-1:0]        duty_ch,
  input  logic [R:0]            duty_in,
  input  logic [CH-1:0]         polarity,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_start,
  output logic [CH-1:0]         duty_pending
);

  localparam logic [R-1:0] CNT_MAX   = R'(cnt_max(R));
  localparam logic [R:0]   DUTY_FULL = (R+1)'(duty_full(R));

  logic          w_run;
  logic          w_start;
  logic          w_tick;
  logic          w_boundary;
  logic [R-1:0]  r_cnt;
  logic [R-1:0]  w_cnt_nxt;
  cnt_dir_e      r_dir;
  cnt_dir_e      w_dir_nxt;
  pwm_mode_e     r_mode_act;
  logic          r_en_d;
  logic          r_period_start;
  logic [R:0]    w_duty_sat;
  logic [31:0]   w_ch_ext;
  logic [CH-1:0] w_wr_hit;

  // The first enabled cycle is a forced boundary; counting starts after it.
  assign w_start = en & ~r_en_d;
  assign w_run   = en & r_en_d;

  pwm_prescaler #(
    .TIMER_BITS (TIMER_BITS)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .en          (w_run),
    .final_value (final_value),
    .tick        (w_tick)
  );

  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    w_dir_nxt = DIR_UP;
    if (r_mode_act == MODE_CENTER) begin
      if ((r_dir == DIR_UP && r_cnt == CNT_MAX) || (r_dir == DIR_DOWN && r_cnt != '0)) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
      if (w_cnt_nxt == '0) begin
        w_dir_nxt = DIR_UP;
      end else if (r_dir == DIR_UP && r_cnt == CNT_MAX) begin
        w_dir_nxt = DIR_DOWN;
      end else begin
        w_dir_nxt = r_dir;
      end
    end
  end

  assign w_boundary = w_start | (w_tick & (w_cnt_nxt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_dir          <= DIR_UP;
      r_mode_act     <= MODE_EDGE;
      r_en_d         <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_en_d         <= en;
      r_period_start <= w_boundary;
      if (!w_run) begin
        r_cnt <= '0;
        r_dir <= DIR_UP;
      end else if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end
      if (w_boundary) begin
        r_mode_act <= pwm_mode_e'(center_mode);
      end
    end
  end

  assign period_start = r_period_start;

  // Saturating on write keeps the stored duty inside 0..2^R.
  assign w_duty_sat = (duty_in > DUTY_FULL) ? DUTY_FULL : duty_in;
  assign w_ch_ext   = 32'(duty_ch);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [R:0] r_shadow;
    logic [R:0] r_duty_act;
    logic       r_pend;
    logic       r_out;
    logic       w_active;

    assign w_wr_hit[i] = duty_wr & (w_ch_ext == 32'(i));
    assign w_active    = ({1'b0, r_cnt} < r_duty_act);

    // A write landing on a boundary keeps its pending bit for the next one.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_shadow   <= '0;
        r_duty_act <= '0;
        r_pend     <= 1'b0;
        r_out      <= 1'b0;
      end else begin
        if (w_boundary && r_pend) begin
          r_duty_act <= r_shadow;
        end
        if (w_wr_hit[i]) begin
          r_shadow <= w_duty_sat;
          r_pend   <= 1'b1;
        end else if (w_boundary) begin
          r_pend <= 1'b0;
        end
        r_out <= en ? (w_active ^ polarity[i]) : polarity[i];
      end
    end

    assign pwm_out[i]      = r_out;
    assign duty_pending[i] = r_pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// Testbench for pwm_multi: table-driven period/duty checks, directed
// corner sequences, and randomized traffic against a phase-based model.
module tb_pwm_multi;

  localparam int CH   = 4;
  localparam int R    = 8;
  localparam int TB   = 10;
  localparam int MAXC = (1 << R) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [TB-1:0] final_value;
  logic          center_mode;
  logic          duty_wr;
  logic [1:0]    duty_ch;
  logic [R:0]    duty_in;
  logic [CH-1:0] polarity;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic [CH-1:0] duty_pending;

  pwm_multi #(.CH(CH), .R(R), .TIMER_BITS(TB)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .final_value  (final_value),
    .center_mode  (center_mode),
    .duty_wr      (duty_wr),
    .duty_ch      (duty_ch),
    .duty_in      (duty_in),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_pending (duty_pending)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_model = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: position within the period as a phase, cnt derived from it.
  int            m_tmr, m_phase;
  bit            m_center, m_en_d, m_ps;
  int            m_shadow [CH];
  int            m_act    [CH];
  bit [CH-1:0]   m_pend, m_out;

  function automatic int m_plen();
    return m_center ? 2 * MAXC : MAXC + 1;
  endfunction

  function automatic int m_cnt();
    return (m_center && m_phase > MAXC) ? 2 * MAXC - m_phase : m_phase;
  endfunction

  task automatic model_step();
    bit bnd;
    bnd = 1'b0;
    if (reset) begin
      m_tmr = 0; m_phase = 0; m_center = 0; m_en_d = 0; m_ps = 0;
      m_pend = '0; m_out = '0;
      for (int i = 0; i < CH; i++) begin m_shadow[i] = 0; m_act[i] = 0; end
      return;
    end
    if (!en) begin
      m_out = polarity; m_tmr = 0; m_phase = 0;
    end else begin
      for (int i = 0; i < CH; i++) m_out[i] = (m_cnt() < m_act[i]) ^ polarity[i];
      if (!m_en_d) begin
        bnd = 1'b1; m_phase = 0; m_tmr = 0;
      end else if (m_tmr == int'(final_value)) begin
        m_tmr = 0;
        m_phase = (m_phase + 1) % m_plen();
        bnd = (m_phase == 0);
      end else begin
        m_tmr = (m_tmr + 1) % (1 << TB);
      end
      if (bnd) begin
        for (int i = 0; i < CH; i++)
          if (m_pend[i]) begin m_act[i] = m_shadow[i]; m_pend[i] = 1'b0; end
        m_center = center_mode;
      end
    end
    m_ps = bnd;
    if (duty_wr && int'(duty_ch) < CH) begin
      m_shadow[duty_ch] = (int'(duty_in) > MAXC + 1) ? MAXC + 1 : int'(duty_in);
      m_pend[duty_ch]   = 1'b1;
    end
    m_en_d = en;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    model_step();
    if (chk_model)
      check("model", {23'd0, pwm_out, period_start, duty_pending}, {23'd0, m_out, m_ps, m_pend});
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; duty_wr = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic write(input int ch, input int d);
    duty_wr = 1'b1; duty_ch = ch[1:0]; duty_in = d[R:0];
    step();
    duty_wr = 1'b0;
  endtask

  task automatic wait_ps(input string name, input int limit, output int n);
    n = 0;
    do begin step(); n++; end while (period_start !== 1'b1 && n < limit);
    if (period_start !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no period_start within %0d cycles, required one", name, limit);
    end
  endtask

  task automatic count_high(input int ch, input int len, output int hi, output int ps_at);
    hi = 0; ps_at = -1;
    for (int k = 1; k <= len; k++) begin
      step();
      hi += int'(pwm_out[ch]);
      if (period_start === 1'b1 && ps_at < 0) ps_at = k;
    end
  endtask

  typedef struct {
    int ch; int duty; bit pol; bit center; int exp_hi; int exp_per;
  } vec_t;
  vec_t vecs [10];

  initial begin
    int n, hi, ps_at;
    vecs[0] = '{0, 128, 1'b0, 1'b0, 128, 256};
    vecs[1] = '{1,   0, 1'b0, 1'b0,   0, 256};
    vecs[2] = '{2, 256, 1'b0, 1'b0, 256, 256};
    vecs[3] = '{3, 300, 1'b0, 1'b0, 256, 256};
    vecs[4] = '{1,   0, 1'b1, 1'b0, 256, 256};
    vecs[5] = '{0,  64, 1'b1, 1'b0, 192, 256};
    vecs[6] = '{1, 255, 1'b0, 1'b0, 255, 256};
    vecs[7] = '{0, 128, 1'b0, 1'b1, 255, 510};
    vecs[8] = '{2, 256, 1'b0, 1'b1, 510, 510};
    vecs[9] = '{3,   1, 1'b0, 1'b1,   1, 510};

    reset = 1'b1; en = 1'b0; final_value = '0; center_mode = 1'b0;
    duty_wr = 1'b0; duty_ch = '0; duty_in = '0; polarity = '0;
    step();
    check("reset_state", {23'd0, pwm_out, period_start, duty_pending}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      do_reset();
      final_value = '0;
      center_mode = vecs[v].center;
      polarity    = 4'(vecs[v].pol) << vecs[v].ch;
      write(vecs[v].ch, vecs[v].duty);
      en = 1'b1;
      wait_ps($sformatf("vec%0d_start", v), 5, n);
      count_high(vecs[v].ch, vecs[v].exp_per, hi, ps_at);
      check($sformatf("vec%0d_high", v), hi, vecs[v].exp_hi);
      check($sformatf("vec%0d_period", v), ps_at, vecs[v].exp_per);
    end

    // Shadow update mid-period, then a write coinciding with the boundary.
    do_reset();
    center_mode = 1'b0; polarity = '0;
    write(1, 200);
    en = 1'b1;
    wait_ps("shadow_start", 5, n);
    steps(100);
    write(1, 64);
    check("shadow_pending_set", duty_pending[1], 1);
    hi = int'(pwm_out[1]); n = 0;
    while (period_start !== 1'b1 && n < 300) begin step(); n++; hi += int'(pwm_out[1]); end
    check("shadow_ps_seen", period_start, 1);
    check("shadow_old_duty_high", hi, 100);
    check("shadow_pending_clr", duty_pending[1], 0);
    count_high(1, 256, hi, ps_at);
    check("shadow_new_duty_high", hi, 64);
    steps(10);
    write(1, 16);
    steps(244);
    write(1, 32);
    check("coincide_ps", period_start, 1);
    check("coincide_pending_kept", duty_pending[1], 1);
    count_high(1, 256, hi, ps_at);
    check("coincide_old_shadow_high", hi, 16);
    check("coincide_pending_clr", duty_pending[1], 0);
    count_high(1, 256, hi, ps_at);
    check("coincide_new_shadow_high", hi, 32);

    // Mode switch waits for the boundary.
    do_reset();
    center_mode = 1'b0;
    en = 1'b1;
    wait_ps("mode_start", 5, n);
    steps(50);
    center_mode = 1'b1;
    wait_ps("mode_edge_rest", 600, n);
    check("mode_edge_rest_len", n, 206);
    wait_ps("mode_center_period", 600, n);
    check("mode_center_period_len", n, 510);
    center_mode = 1'b0;

    // Enable dropped mid-period.
    do_reset();
    polarity = '0;
    write(0, 128);
    en = 1'b1;
    wait_ps("en_start", 5, n);
    steps(49);
    write(0, 20);
    en = 1'b0; polarity = 4'b1010;
    step();
    check("en_off_out", pwm_out, 4'b1010);
    check("en_off_pending", duty_pending[0], 1);
    check("en_off_ps", period_start, 0);
    polarity = 4'b0101;
    step();
    check("en_off_pol_change", pwm_out, 4'b0101);
    polarity = '0; en = 1'b1;
    step();
    check("en_on_ps", period_start, 1);
    check("en_on_pending_clr", duty_pending[0], 0);
    count_high(0, 256, hi, ps_at);
    check("en_on_duty_high", hi, 20);

    // Reset asserted mid-period.
    do_reset();
    write(2, 256);
    write(1, 50);
    en = 1'b1;
    wait_ps("rst_start", 5, n);
    steps(76);
    write(1, 99);
    reset = 1'b1;
    #1;
    check("reset_async", {23'd0, pwm_out, period_start, duty_pending}, 32'd0);
    steps(2);
    reset = 1'b0;
    step();
    check("reset_release_ps", period_start, 1);
    wait_ps("reset_restart", 300, n);
    check("reset_restart_period", n, 256);
    check("reset_duty_cleared", pwm_out, 4'b0000);

    // Prescaler: 196-cycle tick gives a 50176-cycle edge period.
    do_reset();
    final_value = 10'd195;
    en = 1'b1;
    wait_ps("presc_start", 5, n);
    wait_ps("presc_period", 60000, n);
    check("presc_period_len", n, 50176);

    // Randomized traffic against the model.
    final_value = '0;
    do_reset();
    en = 1'b1;
    chk_model = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      duty_wr = ($urandom_range(0, 7) == 0);
      duty_ch = 2'($urandom_range(0, 3));
      duty_in = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 99) == 0)  polarity    = 4'($urandom);
      if ($urandom_range(0, 299) == 0) en          = ~en;
      if ($urandom_range(0, 499) == 0) center_mode = ~center_mode;
      if ($urandom_range(0, 799) == 0) final_value = 10'($urandom_range(0, 2));
      reset = ($urandom_range(0, 1999) == 0);
      step();
    end
    reset = 1'b0; duty_wr = 1'b0;
    step();
    chk_model = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
